// File: rtl/muldiv_pkg.sv
// Shared constants and encodings for the HI/LO multiply/divide sequencer.
// Operation codes match the Op_EX field driven by the execute stage.
package muldiv_pkg;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer: shift-add multiply or restoring divide.
// The accumulator holds {upper, lower}: product halves for MUL, {remainder, quotient} for DIV.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift_rem;
  logic [XLEN:0] w_trial;

  always_comb begin
    w_sum       = {1'b0, i_acc[2*XLEN-1:XLEN]} +
                  (i_acc[0] ? {1'b0, i_operand} : {(XLEN+1){1'b0}});
    w_shift_rem = i_acc[2*XLEN-1:XLEN-1];
    // Top bit of the XLEN+1 wide difference acts as the borrow.
    w_trial     = w_shift_rem - {1'b0, i_operand};
    if (i_div) begin
      if (!w_trial[XLEN]) begin
        o_acc = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end else begin
        o_acc = {w_shift_rem[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Raises MdStall while busy if the execute stage needs HI/LO or a new operation.
module muldiv_ctl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = MD_XLEN,
  parameter int unsigned ITERS = MD_ITERS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start_EX,
  input  logic [1:0]      Op_EX,
  input  logic [XLEN-1:0] SrcA_EX,
  input  logic [XLEN-1:0] SrcB_EX,
  input  logic            ReadHi_EX,
  input  logic            ReadLo_EX,
  input  logic            Kill,
  output logic            Busy,
  output logic            MdStall,
  output logic [XLEN-1:0] HiLoData,
  output logic            DivByZero
);

  localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(ITERS - 1);

  md_state_e         r_state;
  md_op_e            r_op;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_operand;
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_b_zero;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_dbz;

  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [2*XLEN-1:0] w_step_acc;
  logic [XLEN-1:0]   w_fix_hi;
  logic [XLEN-1:0]   w_fix_lo;

  // Only the signed ops (Op_EX[0]==0) take magnitudes; 0x80000000 maps to itself.
  always_comb begin
    w_sign_a = ~Op_EX[0] & SrcA_EX[XLEN-1];
    w_sign_b = ~Op_EX[0] & SrcB_EX[XLEN-1];
    w_abs_a  = w_sign_a ? -SrcA_EX : SrcA_EX;
    w_abs_b  = w_sign_b ? -SrcB_EX : SrcB_EX;
  end

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_acc    (r_acc),
    .i_operand(r_operand),
    .i_div    (r_state == DIV),
    .o_acc    (w_step_acc)
  );

  always_comb begin
    w_fix_hi = r_acc[2*XLEN-1:XLEN];
    w_fix_lo = r_acc[XLEN-1:0];
    unique case (r_op)
      MD_MULT: begin
        if (r_sign_a ^ r_sign_b) begin
          {w_fix_hi, w_fix_lo} = -r_acc;
        end
      end
      MD_DIV: begin
        if (r_sign_a ^ r_sign_b) begin
          w_fix_lo = -r_acc[XLEN-1:0];
        end
        if (r_sign_a) begin
          w_fix_hi = -r_acc[2*XLEN-1:XLEN];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= MD_MULT;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_b_zero  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else if (Kill) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start_EX) begin
            r_state   <= Op_EX[1] ? DIV : MUL;
            r_op      <= md_op_e'(Op_EX);
            r_cnt     <= '0;
            r_acc     <= {{XLEN{1'b0}}, (Op_EX[1] ? w_abs_a : w_abs_b)};
            r_operand <= Op_EX[1] ? w_abs_b : w_abs_a;
            r_sign_a  <= w_sign_a;
            r_sign_b  <= w_sign_b;
            r_b_zero  <= (SrcB_EX == '0);
            r_dbz     <= 1'b0;
          end
        end
        MUL, DIV: begin
          r_acc <= w_step_acc;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LastCnt) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_dbz   <= (r_op == MD_DIV || r_op == MD_DIVU) && r_b_zero;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Busy      = (r_state != IDLE);
    MdStall   = Busy & (Start_EX | ReadHi_EX | ReadLo_EX);
    HiLoData  = ReadHi_EX ? r_hi : r_lo;
    DivByZero = r_dbz;
  end

endmodule

// File: tb/tb_muldiv_ctl.sv
// Self-checking bench for muldiv_ctl: arithmetic reference model plus directed vectors.
module tb_muldiv_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start_EX;
  logic [1:0]  Op_EX;
  logic [31:0] SrcA_EX;
  logic [31:0] SrcB_EX;
  logic        ReadHi_EX;
  logic        ReadLo_EX;
  logic        Kill;
  logic        Busy;
  logic        MdStall;
  logic [31:0] HiLoData;
  logic        DivByZero;

  int total = 0;
  int bad   = 0;

  muldiv_ctl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start_EX (Start_EX),
    .Op_EX    (Op_EX),
    .SrcA_EX  (SrcA_EX),
    .SrcB_EX  (SrcB_EX),
    .ReadHi_EX(ReadHi_EX),
    .ReadLo_EX(ReadLo_EX),
    .Kill     (Kill),
    .Busy     (Busy),
    .MdStall  (MdStall),
    .HiLoData (HiLoData),
    .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {dbz, hi, lo} from plain arithmetic.
  function automatic logic [64:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] u;
    logic [31:0] ones, ua, hi, lo;
    ones = 32'hFFFF_FFFF;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    case (op)
      2'b00: begin
        p = sa * sb;
        model_op = {1'b0, p};
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        model_op = {1'b0, u};
      end
      2'b10: begin
        if (b == 32'b0) begin
          ua = a[31] ? -a : a;
          lo = (a[31] ^ b[31]) ? -ones : ones;
          hi = a[31] ? -ua : ua;
          model_op = {1'b1, hi, lo};
        end else begin
          q = sa / sb;
          r = sa % sb;
          model_op = {1'b0, r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'b0) model_op = {1'b1, a, ones};
        else            model_op = {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Cycle model: remaining busy cycles plus the pending result.
  int          m_busy;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_dbz, p_dbz;
  logic        exp_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_dbz  <= 1'b0;
    end else if (m_busy != 0) begin
      if (Kill) begin
        m_busy <= 0;
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_hi  <= p_hi;
          m_lo  <= p_lo;
          m_dbz <= p_dbz;
        end
      end
    end else if (Start_EX && !Kill) begin
      {p_dbz, p_hi, p_lo} <= model_op(Op_EX, SrcA_EX, SrcB_EX);
      m_busy <= 33;
      m_dbz  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_stall = (m_busy != 0) && (Start_EX || ReadHi_EX || ReadLo_EX);
    chk("busy", 64'(Busy), 64'(m_busy != 0));
    chk("mdstall", 64'(MdStall), 64'(exp_stall));
    chk("divbyzero", 64'(DivByZero), 64'(m_dbz));
    if (!exp_stall) chk("hilodata", 64'(HiLoData), 64'(ReadHi_EX ? m_hi : m_lo));
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    Start_EX = 1'b1;
    Op_EX    = op;
    SrcA_EX  = a;
    SrcB_EX  = b;
    @(posedge clk);
    #1;
    Start_EX = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("idle_timeout", 64'(n), 64'(0));
  endtask

  task automatic lit(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    ReadHi_EX = 1'b1;
    #1;
    chk({nm, "_hi"}, 64'(HiLoData), 64'(hi));
    ReadHi_EX = 1'b0;
    ReadLo_EX = 1'b1;
    #1;
    chk({nm, "_lo"}, 64'(HiLoData), 64'(lo));
    ReadLo_EX = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; Start_EX = 1'b0; Op_EX = 2'b00; SrcA_EX = '0; SrcB_EX = '0;
    ReadHi_EX = 1'b0; ReadLo_EX = 1'b0; Kill = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(Busy), 64'(0));
    lit("reset", 32'h0, 32'h0);

    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_idle(n);
    chk("mult_busy_cycles", 64'(n), 64'(33));
    lit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    lit("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    lit("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(2'b11, 32'h1234, 32'h0);
    wait_idle(n);
    lit("divu0", 32'h0000_1234, 32'hFFFF_FFFF);
    chk("dbz_set", 64'(DivByZero), 64'(1));

    issue(2'b00, 32'd3, 32'd4);
    @(negedge clk);
    chk("dbz_clear", 64'(DivByZero), 64'(0));
    wait_idle(n);
    lit("mult34", 32'h0, 32'd12);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    lit("div_ovf", 32'h0, 32'h8000_0000);
    chk("div_ovf_dbz", 64'(DivByZero), 64'(0));

    // MFHI five cycles after a DIV start waits out the rest of the operation.
    issue(2'b10, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 ReadHi_EX = 1'b1;
    n = 0;
    @(negedge clk);
    while (MdStall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mfhi_stall_cycles", 64'(n), 64'(28));
    chk("mfhi_data", 64'(HiLoData), 64'(2));
    ReadHi_EX = 1'b0;

    // Back-to-back: a MULT held on Start_EX while a DIV is in flight.
    @(posedge clk);
    #1;
    Start_EX = 1'b1; Op_EX = 2'b11; SrcA_EX = 32'd1000; SrcB_EX = 32'd10;
    @(posedge clk);
    #1;
    Op_EX = 2'b00; SrcA_EX = 32'd3; SrcB_EX = 32'd5;
    n = 0;
    @(negedge clk);
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("held_start_wait", 64'(n), 64'(33));
    lit("divu_b2b", 32'h0, 32'd100);
    @(posedge clk);
    #1 Start_EX = 1'b0;
    chk("held_start_accepted", 64'(Busy), 64'(1));
    wait_idle(n);
    lit("b2b_mult", 32'h0, 32'd15);

    // Asynchronous reset in the middle of an operation.
    issue(2'b00, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(Busy), 64'(0));
    lit("rst_mid", 32'h0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Kill keeps the previously committed HI/LO.
    issue(2'b01, 32'h8000_0001, 32'd2);
    wait_idle(n);
    lit("pre_kill", 32'h1, 32'h2);
    issue(2'b00, 32'd5, 32'd5);
    repeat (20) @(posedge clk);
    #1 Kill = 1'b1;
    @(posedge clk);
    #1 Kill = 1'b0;
    chk("kill_busy", 64'(Busy), 64'(0));
    lit("kill", 32'h1, 32'h2);

    // Kill together with Start_EX while idle suppresses acceptance.
    @(posedge clk);
    #1;
    Start_EX = 1'b1; Kill = 1'b1; Op_EX = 2'b00; SrcA_EX = 32'd9; SrcB_EX = 32'd9;
    @(posedge clk);
    #1;
    Start_EX = 1'b0; Kill = 1'b0;
    chk("kill_start_busy", 64'(Busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    lit("kill_start", 32'h1, 32'h2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctl.md
Name: muldiv_ctl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core.
- Sits beside the execute stage and accepts MULT/MULTU/DIV/DIVU operations.
- Runs a 32-step shift-add or restoring-divide sequence, then commits HI/LO.
- Generates the stall request feeding the pipeline's AnyStall when a later MF*/MULT/DIV collides with an operation still in flight.

Parameters:
- XLEN, 32, operand/result width.
- ITERS, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- Start_EX  in  1  valid MULT/MULTU/DIV/DIVU in execute this cycle.
- Op_EX  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA_EX  in  XLEN  rs operand (multiplicand/dividend).
- SrcB_EX  in  XLEN  rt operand (multiplier/divisor).
- ReadHi_EX  in  1  MFHI in execute.
- ReadLo_EX  in  1  MFLO in execute.
- Kill  in  1  synchronous abort of the in-flight operation (pipeline flush of the issuing instruction).
- Busy  out  1  sequencer not IDLE.
- MdStall  out  1  stall request to the pipeline.
- HiLoData  out  XLEN  HI if ReadHi_EX, else LO.
- DivByZero  out  1  sticky flag: last committed divide had a zero divisor.

Behaviour:
- Reset (async, rst_n=0): state IDLE, HI=LO=0, count=0, DivByZero=0, Busy=0, MdStall=0. Reset mid-operation discards the operation; HI/LO read 0 afterwards.
- States:
  - IDLE.
  - MUL: ITERS cycles.
  - DIV: ITERS cycles.
  - FIX: 1 cycle sign correction and commit.
- IDLE -> MUL or DIV on a clk edge with Start_EX=1 and Busy=0.
  - Latch |A| and |B| as unsigned XLEN values; signed ops only, so 0x80000000 stays 0x80000000.
  - Latch signA, signB and op; count=0.
- MUL: 2*XLEN accumulator; each cycle add multiplicand if multiplier LSB=1, then shift right. count increments; at count=ITERS-1 go to FIX.
- DIV: restoring divide; each cycle shift the remainder:quotient pair left, trial-subtract the divisor, and set the quotient bit if the result is non-negative. Same count rule, then to FIX.
- FIX:
  - Signed MULT: negate the 64-bit product if signA^signB.
  - Signed DIV: quotient negated if signA^signB; remainder negated if signA.
  - Write HI (upper/remainder) and LO (lower/quotient); return to IDLE.
- Latency: HI/LO updated on the 34th rising edge counting the accepting edge as 1. Busy=1 for 33 cycles after acceptance.
- MdStall = Busy & (Start_EX | ReadHi_EX | ReadLo_EX), combinational. A stalled Start_EX is held by the pipeline and accepted on the first edge with Busy=0. The FIX->IDLE edge commits HI/LO before a stalled MF* reads.
- HiLoData: combinational from HI/LO registers; valid only when MdStall=0. ReadHi_EX and ReadLo_EX both high: HI wins.
- Divide by zero: produces the natural restoring result, LO=0xFFFFFFFF and HI=|dividend|, sign-fixed per the rules above. DivByZero=1 at commit; cleared at the next accepted Start_EX.
- DIV 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0 (wraps, no flag).
- Kill: when Busy, the next edge returns to IDLE with HI/LO and DivByZero unchanged. Kill with Start_EX in IDLE suppresses acceptance. Kill has priority over all transitions except reset.
- Start_EX in FIX: stalls; accepted next cycle.

Decomposition:
- Package muldiv_pkg holds:
  - op codes MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - state encoding IDLE/MUL/DIV/FIX;
  - XLEN and ITERS constants.
- One sub-module, muldiv_step: purely combinational single iteration (shift-add or trial-subtract) taking {acc, operand, mode}. The controller registers state, count, accumulator, HI and LO.

Test Plan:
- MULT 7 x 0xFFFFFFFD (-3) -> after 34 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy high exactly 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234, DivByZero=1. The next MULT start clears DivByZero.
- MFHI asserted 5 cycles after a DIV start -> MdStall=1 for 28 cycles; HiLoData equals the new HI on the first unstalled cycle. Back-to-back MULT is held and accepted the cycle Busy falls.
- rst_n low at iteration 10 -> Busy=0, HI=LO=0 immediately. Kill at iteration 20 after a prior result HI=1, LO=2 -> IDLE next edge, HI=1, LO=2 retained.
